// File: rtl/data_memory_access_unit.sv
// Load/store initiator between the memory stage and the data bus: splits
// word-crossing accesses, aligns store lanes and aligns/extends load data.
module data_memory_access_unit #(
  parameter bit MISALIGNED_SPLIT = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_address,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic [31:0] bus_address,
  output logic [31:0] bus_write_data,
  output logic [3:0]  bus_byte_enable,
  output logic        bus_read_enable,
  output logic        bus_write_enable,
  input  logic [31:0] bus_read_data
);
  typedef enum logic [2:0] {IDLE, ACC0, ACC1, CAPT, RESP} state_t;

  state_t      state, state_nxt;
  logic        ready_en;
  logic        accept;
  logic [3:0]  req_size;
  logic [7:0]  req_mask;
  logic        req_split;
  logic        req_err;
  logic [31:0] req_bytes;
  logic [63:0] req_lanes;

  logic        write_p0;
  logic [2:0]  funct3_p0;
  logic [31:0] base_p0;
  logic [1:0]  offset_p0;
  logic [7:0]  mask_p0;
  logic [63:0] wdata_p0;
  logic        split_p0;
  logic        err_p0;
  logic [31:0] word0_p1;
  logic [31:0] rdata_p2;
  logic [63:0] merged;

  function automatic logic [3:0] size_mask(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic illegal_funct3(input logic wr, input logic [2:0] funct3);
    if (wr) illegal_funct3 = (funct3 > 3'b010);
    else    illegal_funct3 = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
  endfunction

  function automatic logic [31:0] align_extend(input logic [63:0] words,
                                               input logic [1:0]  offset,
                                               input logic [2:0]  funct3);
    logic [63:0] shifted;
    shifted = words >> {offset, 3'b000};
    case (funct3)
      3'b000:  align_extend = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  align_extend = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  align_extend = {24'h0, shifted[7:0]};
      3'b101:  align_extend = {16'h0, shifted[15:0]};
      default: align_extend = shifted[31:0];
    endcase
  endfunction

  // Request decode, evaluated against the live request fields
  always_comb begin
    accept    = req_valid & ready_en & reset & (state == IDLE);
    req_size  = size_mask(req_funct3);
    req_mask  = {4'b0000, req_size} << req_address[1:0];
    req_split = |req_mask[7:4];
    req_err   = illegal_funct3(req_write, req_funct3) | (req_split & ~MISALIGNED_SPLIT);
    req_bytes = req_wdata & {{8{req_size[3]}}, {8{req_size[2]}},
                             {8{req_size[1]}}, {8{req_size[0]}}};
    req_lanes = {32'h0, req_bytes} << {req_address[1:0], 3'b000};
    merged    = split_p0 ? {bus_read_data, word0_p1} : {32'h0, bus_read_data};
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= IDLE;
      ready_en <= 1'b0;
    end else begin
      state    <= state_nxt;
      ready_en <= 1'b1;
    end
  end

  // Stage p0: request capture; p1: first read word; p2: formatted response
  always_ff @(posedge clock) begin
    if (accept) begin
      write_p0  <= req_write;
      funct3_p0 <= req_funct3;
      base_p0   <= {req_address[31:2], 2'b00};
      offset_p0 <= req_address[1:0];
      mask_p0   <= req_mask;
      wdata_p0  <= req_write ? req_lanes : 64'h0;
      split_p0  <= req_split;
      err_p0    <= req_err;
    end
    if (state == ACC1 && !write_p0) word0_p1 <= bus_read_data;
    if (accept)              rdata_p2 <= 32'h0;
    else if (state == CAPT)  rdata_p2 <= align_extend(merged, offset_p0, funct3_p0);
  end

  // Outputs are forced low while reset is held so an abort emits no strobe
  always_comb begin
    state_nxt        = state;
    req_ready        = 1'b0;
    rsp_valid        = 1'b0;
    rsp_error        = 1'b0;
    rsp_rdata        = 32'h0;
    bus_address      = 32'h0;
    bus_write_data   = 32'h0;
    bus_byte_enable  = 4'h0;
    bus_read_enable  = 1'b0;
    bus_write_enable = 1'b0;
    if (reset) begin
      case (state)
        IDLE: begin
          req_ready = ready_en;
          if (accept) state_nxt = req_err ? RESP : ACC0;
        end
        ACC0: begin
          bus_address      = base_p0;
          bus_byte_enable  = mask_p0[3:0];
          bus_write_data   = wdata_p0[31:0];
          bus_write_enable = write_p0;
          bus_read_enable  = ~write_p0;
          if (split_p0)      state_nxt = ACC1;
          else if (write_p0) state_nxt = RESP;
          else               state_nxt = CAPT;
        end
        ACC1: begin
          bus_address      = base_p0 + 32'd4;
          bus_byte_enable  = mask_p0[7:4];
          bus_write_data   = wdata_p0[63:32];
          bus_write_enable = write_p0;
          bus_read_enable  = ~write_p0;
          state_nxt        = write_p0 ? RESP : CAPT;
        end
        CAPT: begin
          bus_address     = split_p0 ? base_p0 + 32'd4 : base_p0;
          bus_read_enable = 1'b1;
          state_nxt       = RESP;
        end
        RESP: begin
          rsp_valid = 1'b1;
          rsp_error = err_p0;
          rsp_rdata = rdata_p2;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end
endmodule
